// File: rtl/tswitch_pkg.sv
// Shared switch types: data/tag widths, response type and the completion source
// used by resp_scheduler for its round-robin pointer and slot bookkeeping.
package tswitch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 8;

    typedef enum logic [1:0] {
        RESP_DATA = 2'd0,
        RESP_ACK  = 2'd1
    } resp_t;

    typedef enum logic {
        SRC_REDUCE = 1'b0,
        SRC_MC     = 1'b1
    } resp_src_t;

    function automatic resp_src_t other_src(input resp_src_t s);
        return (s == SRC_REDUCE) ? SRC_MC : SRC_REDUCE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally. The caller only pushes when there is room (or a pop).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (push && !pop)      r_count <= r_count + (AW+1)'(1);
            else if (pop && !push) r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage carries no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/resp_scheduler.sv
// Merges reduce/multicast completions into one registered per-port response slot.
// Define RESP_STATS_EN to build the handshake/drop statistics counters.
module resp_scheduler
    import tswitch_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int PORT_BITS  = $clog2(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reduce_done,
    input  logic [DATA_WIDTH-1:0] reduce_result,
    input  logic [TAG_WIDTH-1:0]  reduce_tag,
    input  logic [PORT_BITS-1:0]  reduce_dst_port,
    input  logic                  mc_done,
    input  logic [TAG_WIDTH-1:0]  mc_done_tag,
    input  logic [PORT_BITS-1:0]  mc_done_src_port,
    output logic [NUM_PORTS-1:0]  port_resp_valid,
    output resp_t                 port_resp_type [NUM_PORTS],
    output logic [DATA_WIDTH-1:0] port_resp_data [NUM_PORTS],
    output logic [TAG_WIDTH-1:0]  port_resp_tag  [NUM_PORTS],
    input  logic [NUM_PORTS-1:0]  port_resp_ready,
    output logic                  overflow,
    output logic                  busy,
    output logic [31:0]           stat_data_cnt,
    output logic [31:0]           stat_ack_cnt,
    output logic [31:0]           stat_drop_cnt
);

    localparam int RED_W = PORT_BITS + TAG_WIDTH + DATA_WIDTH;
    localparam int MC_W  = PORT_BITS + TAG_WIDTH;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [RED_W-1:0]      w_red_dout;
    logic                  w_red_full, w_red_empty, w_red_push, w_red_pop, w_red_drop;
    logic [CW-1:0]         w_red_count;
    logic [PORT_BITS-1:0]  w_red_dst;
    logic [TAG_WIDTH-1:0]  w_red_tag;
    logic [DATA_WIDTH-1:0] w_red_data;

    logic [MC_W-1:0]       w_mc_dout;
    logic                  w_mc_full, w_mc_empty, w_mc_push, w_mc_pop, w_mc_drop;
    logic [CW-1:0]         w_mc_count;
    logic [PORT_BITS-1:0]  w_mc_src;
    logic [TAG_WIDTH-1:0]  w_mc_tag;

    logic                  w_slot_load, w_any_head;
    resp_src_t             w_sel_src;

    logic                  r_slot_valid;
    logic [PORT_BITS-1:0]  r_slot_port;
    resp_t                 r_slot_type;
    logic [DATA_WIDTH-1:0] r_slot_data;
    logic [TAG_WIDTH-1:0]  r_slot_tag;
    resp_src_t             r_rr;
    logic                  r_overflow;

    sync_fifo #(.WIDTH(RED_W), .DEPTH(FIFO_DEPTH)) u_red_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_red_push),
        .din   ({reduce_dst_port, reduce_tag, reduce_result}),
        .pop   (w_red_pop),
        .dout  (w_red_dout),
        .full  (w_red_full),
        .empty (w_red_empty),
        .count (w_red_count)
    );

    sync_fifo #(.WIDTH(MC_W), .DEPTH(FIFO_DEPTH)) u_mc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_mc_push),
        .din   ({mc_done_src_port, mc_done_tag}),
        .pop   (w_mc_pop),
        .dout  (w_mc_dout),
        .full  (w_mc_full),
        .empty (w_mc_empty),
        .count (w_mc_count)
    );

    assign {w_red_dst, w_red_tag, w_red_data} = w_red_dout;
    assign {w_mc_src, w_mc_tag}               = w_mc_dout;

    // The slot accepts a new head when empty or when its handshake completes now.
    assign w_slot_load = !r_slot_valid || port_resp_ready[r_slot_port];
    assign w_any_head  = !w_red_empty || !w_mc_empty;

    always_comb begin
        w_sel_src = SRC_REDUCE;
        if (!w_red_empty && !w_mc_empty) w_sel_src = r_rr;
        else if (!w_mc_empty)            w_sel_src = SRC_MC;
    end

    assign w_red_pop  = w_slot_load && !w_red_empty && (w_sel_src == SRC_REDUCE);
    assign w_mc_pop   = w_slot_load && !w_mc_empty  && (w_sel_src == SRC_MC);
    // A full FIFO still accepts a pulse when its head leaves in the same cycle.
    assign w_red_push = reduce_done && (!w_red_full || w_red_pop);
    assign w_mc_push  = mc_done     && (!w_mc_full  || w_mc_pop);
    assign w_red_drop = reduce_done && !w_red_push;
    assign w_mc_drop  = mc_done     && !w_mc_push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_valid <= 1'b0;
            r_rr         <= SRC_REDUCE;
            r_overflow   <= 1'b0;
        end else begin
            if (w_slot_load) begin
                r_slot_valid <= w_any_head;
                if (w_any_head) r_rr <= other_src(w_sel_src);
            end
            if (w_red_drop || w_mc_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_slot_load && w_any_head) begin
            if (w_sel_src == SRC_REDUCE) begin
                r_slot_port <= w_red_dst;
                r_slot_type <= RESP_DATA;
                r_slot_data <= w_red_data;
                r_slot_tag  <= w_red_tag;
            end else begin
                r_slot_port <= w_mc_src;
                r_slot_type <= RESP_ACK;
                r_slot_data <= '0;
                r_slot_tag  <= w_mc_tag;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_resp_valid[i] = r_slot_valid && (r_slot_port == PORT_BITS'(i));
            port_resp_type[i]  = r_slot_type;
            port_resp_data[i]  = r_slot_data;
            port_resp_tag[i]   = r_slot_tag;
        end
    end

    assign overflow = r_overflow;
    assign busy     = r_slot_valid || (w_red_count != '0) || (w_mc_count != '0);

`ifdef RESP_STATS_EN
    logic        w_hs;
    logic [31:0] r_stat_data, r_stat_ack, r_stat_drop;

    assign w_hs = r_slot_valid && port_resp_ready[r_slot_port];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_data <= '0;
            r_stat_ack  <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_hs && r_slot_type == RESP_DATA) r_stat_data <= r_stat_data + 32'd1;
            if (w_hs && r_slot_type == RESP_ACK)  r_stat_ack  <= r_stat_ack + 32'd1;
            r_stat_drop <= r_stat_drop + 32'(w_red_drop) + 32'(w_mc_drop);
        end
    end

    assign stat_data_cnt = r_stat_data;
    assign stat_ack_cnt  = r_stat_ack;
    assign stat_drop_cnt = r_stat_drop;
`else
    assign stat_data_cnt = '0;
    assign stat_ack_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: doc/resp_scheduler.md
Name: resp_scheduler

Overview:
Shares the per-port response channel between the two completion sources: the reduction engine and the multicast engine. Each source emits one-cycle done pulses with no backpressure, so each gets its own small FIFO. The FIFO heads are arbitrated round-robin into a single registered response slot. That slot is routed to the destination port with valid/ready, which decouples engine completion timing from port backpressure.

Parameters:
NUM_PORTS, 4, number of switch ports.
FIFO_DEPTH, 4, entries per source FIFO; power of 2, ≥2.
PORT_BITS, $clog2(NUM_PORTS), port index width (localparam).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
reduce_done  in  1  reduction completion pulse
reduce_result  in  DATA_WIDTH  reduced data
reduce_tag  in  TAG_WIDTH  request tag
reduce_dst_port  in  PORT_BITS  destination port
mc_done  in  1  multicast completion pulse
mc_done_tag  in  TAG_WIDTH  request tag
mc_done_src_port  in  PORT_BITS  originating port (response destination)
port_resp_valid  out  NUM_PORTS  per-port response valid
port_resp_type  out  2 x NUM_PORTS (unpacked)  resp_t
port_resp_data  out  DATA_WIDTH x NUM_PORTS (unpacked)  response data
port_resp_tag  out  TAG_WIDTH x NUM_PORTS (unpacked)  response tag
port_resp_ready  in  NUM_PORTS  per-port ready
overflow  out  1  sticky: a completion was dropped
busy  out  1  any FIFO non-empty or slot occupied
stat_data_cnt, stat_ack_cnt, stat_drop_cnt  out  32 each  statistics (see Optional Feature)

Behaviour:
- Reset: one clock and synchronous active-low reset (rst_n). On reset:
  - FIFOs empty; output slot empty; port_resp_valid=0; overflow=0; busy=0; rr pointer selects the reduce FIFO first; stats=0.
  - Reset mid-operation discards all pending completions, with no responses issued.
- FIFO entries:
  - Reduce FIFO entry = {dst, tag, data}.
  - MC FIFO entry = {src_port, tag}.
- Push rule: a done pulse pushes if count<FIFO_DEPTH, or if count==FIFO_DEPTH and that FIFO pops in the same cycle. Otherwise the entry is dropped and overflow is set (cleared only by reset).
- Concurrent pulses: reduce_done and mc_done in the same cycle push both FIFOs independently.
- Slot load condition: slot empty, or slot occupied and port_resp_ready[slot_port]=1 (handshake completes this cycle).
- Arbitration at slot load:
  - If both FIFO heads are valid, the rr pointer picks the source, then the pointer toggles to the other source.
  - If only one head is valid, that source is taken and the pointer is set to the other source.
  - If neither is valid, the slot empties after a handshake.
- Slot contents:
  - Reduce source: type=RESP_DATA, data=result.
  - MC source: type=RESP_ACK, data=0.
- Outputs: port_resp_valid[i]=slot_valid && slot_port==i. For every i, port_resp_type/data/tag[i] carry the slot contents.
- Latency and throughput:
  - A done pulse in cycle 0 is written to its FIFO at edge 1, loaded into the slot at edge 2, and port_resp_valid is high in cycle 2. Minimum latency is 2 cycles.
  - Back-to-back handshakes sustain 1 response/cycle.
- Valid/ready: slot contents are stable while valid && !ready. Valid never drops before ready.
- busy = slot_valid | reduce FIFO non-empty | MC FIFO non-empty.

Optional Feature:
- Macro: RESP_STATS_EN.
- Defined:
  - stat_data_cnt increments per RESP_DATA handshake.
  - stat_ack_cnt increments per RESP_ACK handshake.
  - stat_drop_cnt increments per dropped completion; if both sources drop in one cycle, it adds 2.
  - All three are 32-bit and wrap.
- Undefined: the stat ports remain present, tied to 0, with no counter logic.

Decomposition:
- tswitch_pkg: DATA_WIDTH, TAG_WIDTH and resp_t (RESP_DATA, RESP_ACK) are already there. Add a resp_src_t enum (SRC_REDUCE, SRC_MC) for the rr pointer and slot source.
- One sub-module, sync_fifo: parameterised WIDTH/DEPTH, push/pop/full/empty/count, synchronous active-low reset. It is instantiated twice.

Test Plan:
1. Single reduce_done (dst=2, tag=5, result=0xDEAD), port 2 ready held 1 -> in cycle 2 only port_resp_valid[2]=1, type=RESP_DATA, data=0xDEAD, tag=5, for exactly one cycle.
2. reduce_done(dst=1, tag=1) and mc_done(src=3, tag=2) in the same cycle, all ready=1 -> port1 DATA in cycle 2, then port3 ACK (data=0) in cycle 3; busy=0 by cycle 4.
3. Port 0 ready=0 for 10 cycles while 6 mc_done (src=0) pulses arrive with FIFO_DEPTH=4 -> slot holds entry 1; FIFO holds 4; 1 dropped; overflow=1 (stat_drop_cnt=1 with RESP_STATS_EN). After ready is raised, 5 ACKs arrive in tag order.
4. Both FIFOs preloaded with 3 entries each, ready=1 -> output order alternates R,M,R,M,R,M, starting with R after reset.
5. FIFO full and port ready in the same cycle as a new done pulse -> the pulse is accepted with no drop and overflow stays 0.
6. rst_n low for 1 cycle with 2 entries queued and slot valid -> the next cycle has port_resp_valid=0, busy=0, overflow=0, and no stale response follows.
